// File: rtl/seq_decoder.sv
// Registered N-to-M line decoder with three-input enable gating, selectable
// polarity and a scan mode that strobes each line for SCAN_DIV cycles.
module seq_decoder #(
    parameter int SEL_W      = 3,
    parameter int OUT_N      = 8,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter int SCAN_DIV   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] sel,
    input  logic [2:0]       en,
    input  logic             mode,
    input  logic             load,
    output logic [OUT_N-1:0] out,
    output logic [SEL_W-1:0] idx,
    output logic             wrap
);

    localparam int               CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SCAN_DIV - 1);
    localparam logic [SEL_W-1:0] IDX_MAX  = SEL_W'(OUT_N - 1);
    localparam logic [OUT_N-1:0] INACTIVE = ACTIVE_LOW ? '1 : '0;

    logic [OUT_N-1:0] out_q, out_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             mode_q;
    logic             ena;
    logic             sel_ok;

    function automatic logic [OUT_N-1:0] line(input logic [SEL_W-1:0] code);
        logic [OUT_N-1:0] v;
        for (int k = 0; k < OUT_N; k++) begin
            v[k] = (code == SEL_W'(k));
        end
        return ACTIVE_LOW ? ~v : v;
    endfunction

    assign ena    = en[0] & ~en[1] & ~en[2];
    assign sel_ok = (32'(sel) < 32'(OUT_N));

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= INACTIVE;
            idx_q  <= '0;
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            // Treat reset as already in scan so a scan from reset counts from its first edge.
            mode_q <= 1'b1;
        end else begin
            out_q  <= out_d;
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            mode_q <= mode;
        end
    end

    always_comb begin
        out_d  = INACTIVE;
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (!mode) begin
            if (ena && sel_ok) begin
                out_d = line(sel);
            end
        end else if (load) begin
            idx_d = sel_ok ? sel : '0;
            cnt_d = '0;
            if (ena) begin
                out_d = line(idx_d);
            end
        end else if (!mode_q) begin
            // Entering scan: restart the dwell so the held line gets a full period.
            cnt_d = '0;
            if (ena) begin
                out_d = line(idx_q);
            end
        end else if (ena) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
                if (idx_q == IDX_MAX) begin
                    idx_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            out_d = line(idx_d);
        end
    end

    assign out  = out_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_seq_decoder.sv
// Directed bench for seq_decoder: default 8-line instance plus a 6-line
// instance sharing the same stimulus.
module tb_seq_decoder;

    logic       clk;
    logic       rst;
    logic [2:0] sel;
    logic [2:0] en;
    logic       mode;
    logic       load;
    logic [7:0] out8;
    logic [2:0] idx8;
    logic       wrap8;
    logic [5:0] out6;
    logic [2:0] idx6;
    logic       wrap6;

    int n_checks;
    int n_fail;

    seq_decoder dut (
        .clk(clk), .rst(rst), .sel(sel), .en(en), .mode(mode), .load(load),
        .out(out8), .idx(idx8), .wrap(wrap8)
    );

    seq_decoder #(.SEL_W(3), .OUT_N(6), .ACTIVE_LOW(1'b1), .SCAN_DIV(4)) dut6 (
        .clk(clk), .rst(rst), .sel(sel), .en(en), .mode(mode), .load(load),
        .out(out6), .idx(idx6), .wrap(wrap6)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] low8(input int i);
        logic [7:0] one;
        one = 8'd1;
        return ~(one << i);
    endfunction

    function automatic logic [5:0] low6(input int i);
        logic [5:0] one;
        one = 6'd1;
        return ~(one << i);
    endfunction

    task automatic do_reset(input logic scan);
        rst  = 1'b1;
        mode = scan;
        load = 1'b0;
        en   = 3'b001;
        step(1);
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        sel  = 3'd0;
        en   = 3'b001;
        mode = 1'b0;
        load = 1'b0;
        rst  = 1'b1;
        step(2);
        rst = 1'b0;
        check("reset_out8", 32'(out8), 32'h0FF);
        check("reset_idx8", 32'(idx8), 32'd0);
        check("reset_wrap8", 32'(wrap8), 32'd0);
        check("reset_out6", 32'(out6), 32'h3F);

        // direct decode
        sel = 3'd7; step(1);
        check("direct_sel7", 32'(out8), 32'h7F);
        sel = 3'd0; step(1);
        check("direct_sel0", 32'(out8), 32'hFE);
        sel = 3'd6; step(1);
        check("direct_sel6_n8", 32'(out8), 32'hBF);
        check("direct_sel6_n6", 32'(out6), 32'h3F);
        sel = 3'd5; step(1);
        check("direct_sel5_n6", 32'(out6), 32'h1F);
        check("direct_sel5_n8", 32'(out8), 32'hDF);

        // each disabled enable pattern
        sel = 3'd3; en = 3'b011; step(1);
        check("dis011_out", 32'(out8), 32'hFF);
        check("dis011_idx", 32'(idx8), 32'd0);
        check("dis011_wrap", 32'(wrap8), 32'd0);
        en = 3'b000; step(1);
        check("dis000_out", 32'(out8), 32'hFF);
        en = 3'b101; step(1);
        check("dis101_out", 32'(out8), 32'hFF);
        en = 3'b001; step(1);
        check("reenable_out", 32'(out8), 32'hF7);

        // scan from reset: both widths, full wrap
        do_reset(1'b1);
        for (int c = 1; c <= 32; c++) begin
            step(1);
            check("scan_idx8", 32'(idx8), 32'((c / 4) % 8));
            check("scan_wrap8", 32'(wrap8), 32'(c == 32));
            check("scan_out8", 32'(out8), 32'(low8((c / 4) % 8)));
            check("scan_idx6", 32'(idx6), 32'((c / 4) % 6));
            check("scan_wrap6", 32'(wrap6), 32'(c == 24));
        end

        // load beats a pending advance
        do_reset(1'b1);
        step(23);
        check("pre_load_idx", 32'(idx8), 32'd5);
        load = 1'b1; sel = 3'd2; step(1);
        load = 1'b0;
        check("load_idx", 32'(idx8), 32'd2);
        check("load_out", 32'(out8), 32'hFB);
        check("load_wrap", 32'(wrap8), 32'd0);
        step(3);
        check("load_dwell_idx", 32'(idx8), 32'd2);
        step(1);
        check("load_next_idx", 32'(idx8), 32'd3);

        // load out of range on the 6-line instance
        load = 1'b1; sel = 3'd7; step(1);
        load = 1'b0;
        check("load7_idx8", 32'(idx8), 32'd7);
        check("load7_idx6", 32'(idx6), 32'd0);
        check("load7_out6", 32'(out6), 32'h3E);

        // disable holds scan state
        en = 3'b100; step(5);
        check("hold_idx", 32'(idx8), 32'd7);
        check("hold_out", 32'(out8), 32'hFF);
        check("hold_wrap", 32'(wrap8), 32'd0);
        en = 3'b001; step(3);
        check("resume_idx", 32'(idx8), 32'd7);
        check("resume_out", 32'(out8), 32'h7F);
        step(1);
        check("resume_wrap_idx", 32'(idx8), 32'd0);
        check("resume_wrap", 32'(wrap8), 32'd1);
        check("resume_wrap_out", 32'(out8), 32'hFE);
        step(1);
        check("wrap_one_cycle", 32'(wrap8), 32'd0);

        // mode 0 -> 1 clears the dwell counter (counter is 1 here)
        mode = 1'b0; sel = 3'd7; step(2);
        check("direct_again", 32'(out8), 32'h7F);
        check("direct_idx_hold", 32'(idx8), 32'd0);
        mode = 1'b1; step(1);
        check("enter_idx", 32'(idx8), 32'd0);
        check("enter_out", 32'(out8), 32'hFE);
        step(3);
        check("enter_dwell_idx", 32'(idx8), 32'd0);
        step(1);
        check("enter_next_idx", 32'(idx8), 32'd1);

        // reset mid-scan
        step(12);
        check("pre_rst_idx", 32'(idx8), 32'd4);
        rst = 1'b1; step(1);
        rst = 1'b0;
        check("midrst_out", 32'(out8), 32'hFF);
        check("midrst_idx", 32'(idx8), 32'd0);
        check("midrst_wrap", 32'(wrap8), 32'd0);
        step(3);
        check("restart_idx", 32'(idx8), 32'd0);
        check("restart_out", 32'(out8), 32'hFE);
        step(1);
        check("restart_next", 32'(idx8), 32'd1);

        // load ignored in direct mode
        mode = 1'b0; load = 1'b1; sel = 3'd3; step(1);
        load = 1'b0;
        check("direct_load_out", 32'(out8), 32'hF7);
        check("direct_load_idx", 32'(idx8), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
